// File: rtl/vga_scan.sv
// Raster timing generator: pixel strobe, scan counters, sync/blank and per-frame move strobe.
// Optional move generation is built only when VGA_MOVE_GEN_EN is defined.
module vga_scan #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter int unsigned PIX_DIV  = 4,
    parameter int unsigned MOVE_DIV = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    output logic       pixpulse,
    output logic [9:0] hcount,
    output logic [9:0] vcount,
    output logic       hsync,
    output logic       vsync,
    output logic       blank,
    output logic       move
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned DIV_W   = $clog2(PIX_DIV);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);
    localparam logic [9:0]       H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]       V_LAST   = 10'(V_TOTAL - 1);

    // 11-bit decode bounds so an end value of exactly 1024 does not wrap
    localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
    localparam logic [10:0] V_ACT    = 11'(V_ACTIVE);
    localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

    logic [DIV_W-1:0] div_q, div_d;
    logic             pix_q, pix_d;
    logic [9:0]       h_q, h_d;
    logic [9:0]       v_q, v_d;
    logic             hs_q, hs_d;
    logic             vs_q, vs_d;
    logic             bl_q, bl_d;
    logic             move_q, move_d;

    always_comb begin
        div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
        pix_d = (div_d == DIV_LAST);

        h_d = h_q;
        v_d = v_q;
        if (pix_q) begin
            if (h_q == H_LAST) begin
                h_d = '0;
                v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
            end else begin
                h_d = h_q + 1'b1;
            end
        end

        // Decoded from next counter values so sync/blank line up with hcount/vcount
        hs_d = !(({1'b0, h_d} >= HS_START) && ({1'b0, h_d} < HS_END));
        vs_d = !(({1'b0, v_d} >= VS_START) && ({1'b0, v_d} < VS_END));
        bl_d = ({1'b0, h_d} >= H_ACT) || ({1'b0, v_d} >= V_ACT);
    end

`ifdef VGA_MOVE_GEN_EN
    localparam logic [7:0] FCNT_LAST = 8'(MOVE_DIV - 1);

    logic [7:0] fcnt_q, fcnt_d;
    logic       move_pt;

    always_comb begin
        // True only in the single pixpulse cycle of the first vblank pixel
        move_pt = pix_d && (h_d == '0) && ({1'b0, v_d} == V_ACT);
        fcnt_d  = fcnt_q;
        move_d  = 1'b0;
        if (move_pt && run) begin
            if (fcnt_q == FCNT_LAST) begin
                move_d = 1'b1;
                fcnt_d = '0;
            end else begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fcnt_q <= '0;
        end else begin
            fcnt_q <= fcnt_d;
        end
    end
`else
    logic unused_run;

    assign unused_run = run | (MOVE_DIV == 0);
    assign move_d     = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q  <= '0;
            pix_q  <= 1'b0;
            h_q    <= '0;
            v_q    <= '0;
            hs_q   <= 1'b1;
            vs_q   <= 1'b1;
            bl_q   <= 1'b0;
            move_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            pix_q  <= pix_d;
            h_q    <= h_d;
            v_q    <= v_d;
            hs_q   <= hs_d;
            vs_q   <= vs_d;
            bl_q   <= bl_d;
            move_q <= move_d;
        end
    end

    assign pixpulse = pix_q;
    assign hcount   = h_q;
    assign vcount   = v_q;
    assign hsync    = hs_q;
    assign vsync    = vs_q;
    assign blank    = bl_q;
    assign move     = move_q;

endmodule

// File: tb/tb_vga_scan.sv
// Bench for vga_scan on a shrunken raster (15x10 pixels, PIX_DIV=4, MOVE_DIV=3).
module tb_vga_scan;

    localparam int unsigned HA = 8, HF = 2, HSW = 3, HB = 2;
    localparam int unsigned VA = 6, VF = 1, VSW = 2, VB = 1;
    localparam int unsigned PD = 4, MD = 3;
    localparam int unsigned HT = HA + HF + HSW + HB;
    localparam int unsigned VT = VA + VF + VSW + VB;
    localparam int unsigned FRAME = HT * VT * PD;
`ifdef VGA_MOVE_GEN_EN
    localparam int unsigned MOVE_EN = 1;
`else
    localparam int unsigned MOVE_EN = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       run;
    logic       pixpulse, hsync, vsync, blank, move;
    logic [9:0] hcount, vcount;

    vga_scan #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
        .PIX_DIV(PD), .MOVE_DIV(MD)
    ) dut (
        .clk(clk), .rst_n(rst_n), .run(run),
        .pixpulse(pixpulse), .hcount(hcount), .vcount(vcount),
        .hsync(hsync), .vsync(vsync), .blank(blank), .move(move)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned t;
        logic        pp;
        logic [9:0]  h;
        logic [9:0]  v;
        logic        hs;
        logic        vs;
        logic        bl;
        logic        mv;
    } vec_t;

    vec_t vecs[17];

    int          total = 0;
    int          bad   = 0;
    int unsigned t;
    int unsigned mf;
    logic        run_e;
    logic [24:0] exp_vec;
    logic [24:0] rst_vec;

    function automatic vec_t mk(input int unsigned tt, input logic pp, input int unsigned h,
                                input int unsigned v, input logic hs, input logic vs,
                                input logic bl, input logic mv);
        vec_t r;
        r.t = tt; r.pp = pp; r.h = 10'(h); r.v = 10'(v);
        r.hs = hs; r.vs = vs; r.bl = bl; r.mv = mv;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at t=%0d: got %0h expected %0h", name, t, act, exp);
        end
    endtask

    // Closed-form raster model indexed by edges since reset release
    task automatic tick();
        int unsigned n;
        logic        pp, hs, vs, bl, mv;
        int unsigned h, v;
        @(posedge clk);
        t++;
        run_e = run;
        #1;
        n  = t / PD;
        pp = ((t % PD) == PD - 1);
        h  = n % HT;
        v  = (n / HT) % VT;
        hs = !(h >= HA + HF && h < HA + HF + HSW);
        vs = !(v >= VA + VF && v < VA + VF + VSW);
        bl = (h >= HA) || (v >= VA);
        mv = 1'b0;
        if (MOVE_EN != 0 && pp && h == 0 && v == VA && run_e) begin
            if (mf == MD - 1) begin
                mv = 1'b1;
                mf = 0;
            end else begin
                mf++;
            end
        end
        exp_vec = {pp, 10'(h), 10'(v), hs, vs, bl, mv};
    endtask

    initial begin
        int unsigned moves, early, first_frame, vs_low, fall1, fall2, waitc;
        logic        prev_vs;

        vecs[0]  = mk(1,   1'b0, 0,  0, 1'b1, 1'b1, 1'b0, 1'b0);
        vecs[1]  = mk(3,   1'b1, 0,  0, 1'b1, 1'b1, 1'b0, 1'b0);
        vecs[2]  = mk(4,   1'b0, 1,  0, 1'b1, 1'b1, 1'b0, 1'b0);
        vecs[3]  = mk(7,   1'b1, 1,  0, 1'b1, 1'b1, 1'b0, 1'b0);
        vecs[4]  = mk(8,   1'b0, 2,  0, 1'b1, 1'b1, 1'b0, 1'b0);
        vecs[5]  = mk(11,  1'b1, 2,  0, 1'b1, 1'b1, 1'b0, 1'b0);
        vecs[6]  = mk(32,  1'b0, 8,  0, 1'b1, 1'b1, 1'b1, 1'b0);
        vecs[7]  = mk(40,  1'b0, 10, 0, 1'b0, 1'b1, 1'b1, 1'b0);
        vecs[8]  = mk(51,  1'b1, 12, 0, 1'b0, 1'b1, 1'b1, 1'b0);
        vecs[9]  = mk(52,  1'b0, 13, 0, 1'b1, 1'b1, 1'b1, 1'b0);
        vecs[10] = mk(59,  1'b1, 14, 0, 1'b1, 1'b1, 1'b1, 1'b0);
        vecs[11] = mk(60,  1'b0, 0,  1, 1'b1, 1'b1, 1'b0, 1'b0);
        vecs[12] = mk(363, 1'b1, 0,  6, 1'b1, 1'b1, 1'b1, 1'b0);
        vecs[13] = mk(420, 1'b0, 0,  7, 1'b1, 1'b0, 1'b1, 1'b0);
        vecs[14] = mk(540, 1'b0, 0,  9, 1'b1, 1'b1, 1'b1, 1'b0);
        vecs[15] = mk(599, 1'b1, 14, 9, 1'b1, 1'b1, 1'b1, 1'b0);
        vecs[16] = mk(600, 1'b0, 0,  0, 1'b1, 1'b1, 1'b0, 1'b0);

        rst_vec = {1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0};
        rst_n = 1'b0;
        run   = 1'b1;
        t     = 0;
        mf    = 0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", 32'({pixpulse, hcount, vcount, hsync, vsync, blank, move}), 32'(rst_vec));
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 17; i++) begin
            while (t < vecs[i].t) tick();
            check($sformatf("vec%0d.pixpulse", i), 32'(pixpulse), 32'(vecs[i].pp));
            check($sformatf("vec%0d.hcount", i),   32'(hcount),   32'(vecs[i].h));
            check($sformatf("vec%0d.vcount", i),   32'(vcount),   32'(vecs[i].v));
            check($sformatf("vec%0d.hsync", i),    32'(hsync),    32'(vecs[i].hs));
            check($sformatf("vec%0d.vsync", i),    32'(vsync),    32'(vecs[i].vs));
            check($sformatf("vec%0d.blank", i),    32'(blank),    32'(vecs[i].bl));
            check($sformatf("vec%0d.move", i),     32'(move),     32'(vecs[i].mv));
        end

        // Frames 2..10 free-running with run=1
        moves = 0; vs_low = 0; fall1 = 0; fall2 = 0; prev_vs = vsync;
        while (t < 10 * FRAME) begin
            tick();
            check("scan", 32'({pixpulse, hcount, vcount, hsync, vsync, blank, move}), 32'(exp_vec));
            if (move) moves++;
            if (t > FRAME && t <= 2 * FRAME && !vsync) vs_low++;
            if (prev_vs && !vsync) begin
                if (fall1 == 0) fall1 = t;
                else if (fall2 == 0) fall2 = t;
            end
            prev_vs = vsync;
        end
        check("move_count", 32'(moves), 32'(MOVE_EN != 0 ? 3 : 0));
        check("vsync_low_clks", 32'(vs_low), 32'(2 * HT * PD));
        check("frame_period", 32'(fall2 - fall1), 32'(FRAME));

        // Mid-frame asynchronous reset
        waitc = 0;
        while (vcount != 10'd4 && waitc < 2 * FRAME) begin
            tick();
            waitc++;
        end
        check("reach_v4", 32'(vcount), 32'd4);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_async", 32'({pixpulse, hcount, vcount, hsync, vsync, blank, move}), 32'(rst_vec));
        @(posedge clk);
        #1;
        check("midrst_hold", 32'({pixpulse, hcount, vcount, hsync, vsync, blank, move}), 32'(rst_vec));
        @(negedge clk);
        rst_n = 1'b1;
        t     = 0;
        mf    = 0;
        run   = 1'b0;

        early = 0;
        while (t < 4 * FRAME) begin
            tick();
            check("scan_frozen", 32'({pixpulse, hcount, vcount, hsync, vsync, blank, move}), 32'(exp_vec));
            if (move) early++;
        end
        check("no_move_run0", 32'(early), 32'd0);

        run = 1'b1;
        moves = 0; first_frame = 0;
        while (t < 10 * FRAME) begin
            tick();
            check("scan_run", 32'({pixpulse, hcount, vcount, hsync, vsync, blank, move}), 32'(exp_vec));
            if (move) begin
                moves++;
                if (first_frame == 0) first_frame = t / FRAME + 1;
            end
        end
        check("move_count_gated", 32'(moves), 32'(MOVE_EN != 0 ? 2 : 0));
        check("first_move_frame", 32'(first_frame), 32'(MOVE_EN != 0 ? 7 : 0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vga_scan.md
# vga_scan

Raster timing generator for the 640x480@60 display path, running on the 100 MHz system clock. It produces the signals the sprite and ball blocks consume:
- the `pixpulse` pixel-rate strobe;
- the `hcount`/`vcount` scan position;
- sync and blank for the VGA connector;
- the per-frame `move` strobe that advances object positions.

## Interface
Parameters:
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, hsync width (pixels)
- `H_BP`, 48, horizontal back porch (pixels)
- `V_ACTIVE`, 480, visible lines
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vsync width (lines)
- `V_BP`, 33, vertical back porch (lines)
- `PIX_DIV`, 4, clk cycles per pixel (2..16)
- `MOVE_DIV`, 1, frames per `move` strobe (1..256)

Ports:
- `clk`  in  1  100 MHz system clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `run`  in  1  enables `move` generation; low = objects frozen
- `pixpulse`  out  1  one-clk strobe every `PIX_DIV` clks
- `hcount`  out  10  current pixel column, 0..H_TOTAL-1
- `vcount`  out  10  current line, 0..V_TOTAL-1
- `hsync`  out  1  horizontal sync, active-low
- `vsync`  out  1  vertical sync, active-low
- `blank`  out  1  high outside visible area
- `move`  out  1  one-clk object-update strobe, coincident with `pixpulse`

Timing parameters:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 800.
- V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP = 525.
- Both totals must be ≤1024.

## Operation
- **Pixel divider:** `div` counts 0..PIX_DIV-1 every clk and wraps. `pixpulse` is registered and high exactly in the cycle where `div`==PIX_DIV-1.
- **hcount:** advances only on an edge where `pixpulse`=1. At H_TOTAL-1 it wraps to 0 and `vcount` advances. `vcount` wraps from V_TOTAL-1 to 0.
- **hsync:** low iff H_ACTIVE+H_FP ≤ `hcount` < H_ACTIVE+H_FP+H_SYNC, i.e. 656..751.
- **vsync:** low iff V_ACTIVE+V_FP ≤ `vcount` < V_ACTIVE+V_FP+V_SYNC, i.e. 490..491.
- **blank:** high iff `hcount` ≥ H_ACTIVE or `vcount` ≥ V_ACTIVE.
- `hsync`, `vsync` and `blank` are registered from the next counter values. They always describe the current `hcount`/`vcount` with no skew.
- **Move point:** the pixel `hcount`=0, `vcount`=V_ACTIVE, the first vblank pixel. All neighbour sampling by consumers is complete by then.
- **Frame counter:** 8-bit `fcnt`, reset 0. At each move point with `run`=1:
  - if `fcnt`==MOVE_DIV-1: `move`=1 for that cycle and `fcnt`←0;
  - otherwise `fcnt`+1.
- With `run`=0, `fcnt` holds and `move` stays 0.
- `move` is high for exactly one clk, the same cycle `pixpulse`=1 and the counters show the move point.

## Timing
- **Reset values (async, while `rst_n`=0):**
  - `div`=0, `pixpulse`=0, `hcount`=0, `vcount`=0;
  - `hsync`=1, `vsync`=1, `blank`=0;
  - `move`=0, `fcnt`=0.
- **First edges after release (edges counted from 1 after release):**
  - `pixpulse` rises at edge PIX_DIV-1 (edge 3);
  - `hcount`→1 at edge PIX_DIV (edge 4);
  - thereafter period PIX_DIV.
- **Frame timing:**
  - line = H_TOTAL·PIX_DIV = 3200 clks;
  - frame = 3200·525 = 1,680,000 clks;
  - first `move` (MOVE_DIV=1) occurs 480 lines after reset, during the `pixpulse` cycle with `vcount`=480, `hcount`=0.
- **Simultaneous wrap:** on the edge taking `hcount` 799→0 and `vcount` 524→0, both change on that same edge. Outputs then show (0,0) with `blank`=0, `hsync`=`vsync`=1.
- **`run` sampling:** `run` is sampled only at the move point. Toggling it elsewhere has no effect.
- **Reset mid-frame:** all state returns asynchronously to reset values. No partial `move` pulse may be emitted.

## Configuration
- **`VGA_MOVE_GEN_EN` defined:** `fcnt` and `move` generation are present as described.
- **`VGA_MOVE_GEN_EN` undefined:**
  - `move` is tied to 0;
  - `run` is ignored;
  - `fcnt` is not built;
  - `MOVE_DIV` is unused.
- All timing and sync behaviour is identical in both builds.

## Test plan
- **Reset release:** release `rst_n` → `pixpulse` high at edges 3, 7, 11; `hcount`=1 after edge 4 and 2 after edge 8; `vcount`=0; `blank`=0.
- **Horizontal decode:** run one line.
  - `hsync`=0 for exactly 96 `pixpulse` periods, `hcount` 656..751.
  - `blank` high for `hcount` 640..799.
  - `vcount` increments at the 799→0 wrap.
- **Frame wrap:** run 2 frames.
  - `vsync`=0 only at `vcount` 490..491, i.e. 6400 clks.
  - Frame period is 1,680,000 clks.
  - Counters show (0,0) right after (799,524).
- **Move divider:** MOVE_DIV=3, `run`=1 → `move` one clk wide at (0,480), coincident with `pixpulse`, on frames 3, 6, 9 only.
- **Run gating:** `run`=0 for frames 1–4, then 1 → no `move` during frames 1–4; with MOVE_DIV=1, `move` on frame 5.
- **Mid-frame reset:** assert `rst_n`=0 at `vcount`=300 → all outputs at reset values immediately; after release, the first `move` comes 480 lines later.
